// File: rtl/gf2_poly_divider.sv
// Sequential GF(2)[x] long divider: dividend = quotient*divisor ^ remainder, one XOR-shift per cycle.
// Optional macro GF2_DIV_OUTREG_EN adds two register stages on done/quotient/remainder/err.
module gf2_poly_divider #(
  parameter int unsigned N = 409
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           err
);

  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(2 * N);

  typedef enum logic [2:0] {
    StIdle,
    StNorm,
    StDiv,
    StDenorm,
    StDone
  } state_e;

  state_e         state_q, state_d;
  // w_q[2N-1:N+1] is the running remainder; w_q[N:0] holds dividend bits still to be consumed.
  logic [2*N-1:0] w_q, w_d;
  logic [N-1:0]   d_q, d_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [SW-1:0]  s_q, s_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] quot_q, quot_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           err_q, err_d;

  logic           q_bit;
  logic [2*N-1:0] w_step;
  logic           finish;
  logic           done_int;

  // One division step: reduce the top window by the normalised divisor, then advance.
  always_comb begin
    q_bit  = w_q[2*N-1];
    w_step = w_q;
    if (q_bit) begin
      w_step[2*N-1:N] = w_q[2*N-1:N] ^ d_q;
    end
    w_step = w_step << 1;
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    d_d     = d_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    finish  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_d   = dividend;
          d_d   = divisor;
          acc_d = '0;
          s_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = StDone;
            quot_d  = '0;
            rem_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = StNorm;
          end
        end
      end

      StNorm: begin
        if (!d_q[N-1]) begin
          d_d = d_q << 1;
          s_d = s_q + SW'(1);
        end else begin
          // The exit cycle already performs the first of the N+1+s division steps.
          w_d     = w_step;
          acc_d   = {acc_q[2*N-2:0], q_bit};
          cnt_d   = CW'(N - 1) + CW'(s_q);
          state_d = StDiv;
        end
      end

      StDiv: begin
        w_d   = w_step;
        acc_d = {acc_q[2*N-2:0], q_bit};
        if (cnt_q == '0) begin
          if (s_q == '0) begin
            finish = 1'b1;
          end else begin
            cnt_d   = CW'(s_q) - CW'(1);
            state_d = StDenorm;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      StDenorm: begin
        w_d[2*N-1:N+1] = w_q[2*N-1:N+1] >> 1;
        if (cnt_q == '0) begin
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (finish) begin
      state_d = StDone;
      quot_d  = acc_d;
      rem_d   = {1'b0, w_d[2*N-1:N+1]};
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      w_q     <= '0;
      d_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign done_int = (state_q == StDone);

`ifdef GF2_DIV_OUTREG_EN
  logic           done_p1_q, done_p2_q;
  logic [2*N-1:0] quot_p1_q, quot_p2_q;
  logic [N-1:0]   rem_p1_q, rem_p2_q;
  logic           err_p1_q, err_p2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_p1_q <= 1'b0;
      done_p2_q <= 1'b0;
      quot_p1_q <= '0;
      quot_p2_q <= '0;
      rem_p1_q  <= '0;
      rem_p2_q  <= '0;
      err_p1_q  <= 1'b0;
      err_p2_q  <= 1'b0;
    end else begin
      done_p1_q <= done_int;
      done_p2_q <= done_p1_q;
      quot_p1_q <= quot_q;
      quot_p2_q <= quot_p1_q;
      rem_p1_q  <= rem_q;
      rem_p2_q  <= rem_p1_q;
      err_p1_q  <= err_q;
      err_p2_q  <= err_p1_q;
    end
  end

  assign done      = done_p2_q;
  assign quotient  = quot_p2_q;
  assign remainder = rem_p2_q;
  assign err       = err_p2_q;
`else
  assign done      = done_int;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed bench for gf2_poly_divider: N=8 vector table and corner sequences, plus N=409 randoms.
module tb_gf2_poly_divider;

  localparam int unsigned NS = 8;
  localparam int unsigned NB = 409;
`ifdef GF2_DIV_OUTREG_EN
  localparam int OutLat = 2;
`else
  localparam int OutLat = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic            s_start, s_ready, s_done, s_err;
  logic [2*NS-1:0] s_dividend, s_quot;
  logic [NS-1:0]   s_divisor, s_rem;

  logic            b_start, b_ready, b_done, b_err;
  logic [2*NB-1:0] b_dividend, b_quot;
  logic [NB-1:0]   b_divisor, b_rem;

  gf2_poly_divider #(.N(NS)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .start     (s_start),
    .dividend  (s_dividend),
    .divisor   (s_divisor),
    .ready     (s_ready),
    .done      (s_done),
    .quotient  (s_quot),
    .remainder (s_rem),
    .err       (s_err)
  );

  gf2_poly_divider #(.N(NB)) dut_big (
    .clk       (clk),
    .rst       (rst),
    .start     (b_start),
    .dividend  (b_dividend),
    .divisor   (b_divisor),
    .ready     (b_ready),
    .done      (b_done),
    .quotient  (b_quot),
    .remainder (b_rem),
    .err       (b_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        e;
    int          lat;  // rising edges from the accepting edge to the done cycle
  } vec_t;

  // Called at a negedge: waits for ready, then holds start across one rising edge.
  task automatic start_small(input logic [15:0] a, input logic [7:0] b);
    for (int i = 0; i < 8 && !s_ready; i++) @(negedge clk);
    s_dividend = a;
    s_divisor  = b;
    s_start    = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
  endtask

  task automatic wait_small(input int min_k, output int lat, output logic [15:0] q,
                            output logic [7:0] r, output logic e);
    lat = -1;
    q   = '0;
    r   = '0;
    e   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (s_done && k >= min_k) begin
        lat = k;
        q   = s_quot;
        r   = s_rem;
        e   = s_err;
        break;
      end
    end
  endtask

  function automatic logic [NB-1:0] rand_big();
    logic [447:0] t;
    for (int i = 0; i < 14; i++) t[i*32 +: 32] = $urandom;
    return t[NB-1:0];
  endfunction

  function automatic logic [2*NB-1:0] clmul(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [2*NB-1:0] p;
    logic [2*NB-1:0] ae;
    p  = '0;
    ae = {{NB{1'b0}}, a};
    for (int i = 0; i < NB; i++) if (b[i]) p = p ^ (ae << i);
    return p;
  endfunction

  // Random divisor of degree d, dividend = a*b ^ r with deg r < d.
  task automatic run_big(input int d, input string name);
    logic [NB-1:0]   a, b, r, mask;
    logic [2*NB-1:0] prod;
    logic [2*NB-1:0] q;
    logic [NB-1:0]   rem;
    int              s, lat;
    a    = rand_big();
    b    = rand_big();
    mask = (NB'(1) << d) - NB'(1);
    b    = (b & mask) | (NB'(1) << d);
    r    = rand_big() & mask;
    prod = clmul(a, b) ^ {{NB{1'b0}}, r};
    s    = NB - 1 - d;
    for (int i = 0; i < 8 && !b_ready; i++) @(negedge clk);
    b_dividend = prod;
    b_divisor  = b;
    b_start    = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    lat = -1;
    q   = '0;
    rem = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (b_done) begin
        lat = k;
        q   = b_quot;
        rem = b_rem;
        break;
      end
    end
    check({name, ".q"}, q, {{NB{1'b0}}, a});
    check({name, ".r"}, rem, r);
    check({name, ".lat"}, lat, NB + 1 + 3 * s + OutLat);
  endtask

  vec_t        vec[9];
  int          lat, n;
  logic [15:0] q;
  logic [7:0]  r;
  logic        e;

  initial begin
    vec[0] = '{a: 16'h0005, b: 8'h03, q: 16'h0003, r: 8'h00, e: 1'b0, lat: 27};
    vec[1] = '{a: 16'h0007, b: 8'h03, q: 16'h0002, r: 8'h01, e: 1'b0, lat: 27};
    vec[2] = '{a: 16'hFFFF, b: 8'h80, q: 16'h01FF, r: 8'h7F, e: 1'b0, lat: 9};
    vec[3] = '{a: 16'h1234, b: 8'h00, q: 16'h0000, r: 8'h00, e: 1'b1, lat: 0};
    vec[4] = '{a: 16'hABCD, b: 8'h01, q: 16'hABCD, r: 8'h00, e: 1'b0, lat: 30};
    vec[5] = '{a: 16'h00FF, b: 8'h07, q: 16'h0024, r: 8'h03, e: 1'b0, lat: 24};
    vec[6] = '{a: 16'h0001, b: 8'h05, q: 16'h0000, r: 8'h01, e: 1'b0, lat: 24};
    vec[7] = '{a: 16'h8000, b: 8'hFF, q: 16'h0181, r: 8'h7F, e: 1'b0, lat: 9};
    vec[8] = '{a: 16'h0000, b: 8'h0B, q: 16'h0000, r: 8'h00, e: 1'b0, lat: 21};

    rst        = 1'b1;
    s_start    = 1'b0;
    s_dividend = '0;
    s_divisor  = '0;
    b_start    = 1'b0;
    b_dividend = '0;
    b_divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst.s_ready", s_ready, 1'b1);
    check("rst.s_done", s_done, 1'b0);
    check("rst.s_quot", s_quot, 16'h0);
    check("rst.s_rem", s_rem, 8'h0);
    check("rst.s_err", s_err, 1'b0);
    check("rst.b_ready", b_ready, 1'b1);
    check("rst.b_done", b_done, 1'b0);
    check("rst.b_quot", b_quot, '0);
    check("rst.b_rem", b_rem, '0);
    check("rst.b_err", b_err, 1'b0);

    for (int i = 0; i < 9; i++) begin
      start_small(vec[i].a, vec[i].b);
      wait_small(0, lat, q, r, e);
      check($sformatf("v%0d.q", i), q, vec[i].q);
      check($sformatf("v%0d.r", i), r, vec[i].r);
      check($sformatf("v%0d.err", i), e, vec[i].e);
      check($sformatf("v%0d.lat", i), lat, vec[i].lat + OutLat);
    end

    // Divide by zero, then a start two cycles after acceptance must be taken.
    start_small(16'h1234, 8'h00);
    @(negedge clk);
    check("dz.ready_low", s_ready, 1'b0);
    @(negedge clk);
    check("dz.ready_high", s_ready, 1'b1);
    s_dividend = 16'h0005;
    s_divisor  = 8'h03;
    s_start    = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    wait_small(1, lat, q, r, e);
    check("dz.next_lat", lat, 27 + OutLat);
    check("dz.next_q", q, 16'h0003);
    check("dz.next_err", e, 1'b0);

    // A start pulse while busy is ignored and produces no extra result.
    start_small(16'h0007, 8'h03);
    repeat (5) @(negedge clk);
    check("busy.ready", s_ready, 1'b0);
    s_dividend = 16'hFFFF;
    s_divisor  = 8'h80;
    s_start    = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    wait_small(0, lat, q, r, e);
    check("busy.q", q, 16'h0002);
    check("busy.r", r, 8'h01);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_done) n++;
    end
    check("busy.extra_done", n, 0);
    check("hold.q", s_quot, 16'h0002);
    check("hold.r", s_rem, 8'h01);

    // Reset in the middle of DIV aborts without a done pulse.
    start_small(16'h0005, 8'h03);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.ready", s_ready, 1'b1);
    check("abort.done", s_done, 1'b0);
    check("abort.quot", s_quot, 16'h0);
    check("abort.rem", s_rem, 8'h0);
    check("abort.err", s_err, 1'b0);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_done) n++;
    end
    check("abort.no_done", n, 0);
    start_small(16'hFFFF, 8'h80);
    wait_small(0, lat, q, r, e);
    check("abort.next_q", q, 16'h01FF);
    check("abort.next_r", r, 8'h7F);
    check("abort.next_lat", lat, 9 + OutLat);

    run_big(NB - 1, "big_s0");
    run_big(200, "big_d200");
    run_big(3, "big_d3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
